// File: rtl/dp_ram_arb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : dp_ram_arb
// Brief    : Dual-port byte-writable RAM with one-cycle collision arbitration
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module dp_ram_arb #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int OUT_REG    = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_a_i,
    input  logic                      req_b_i,
    output logic                      gnt_a_o,
    output logic                      gnt_b_o,
    input  logic [ADDR_WIDTH-1:0]     addr_a_i,
    input  logic [ADDR_WIDTH-1:0]     addr_b_i,
    input  logic                      we_a_i,
    input  logic                      we_b_i,
    input  logic [DATA_WIDTH/8-1:0]   be_a_i,
    input  logic [DATA_WIDTH/8-1:0]   be_b_i,
    input  logic [DATA_WIDTH-1:0]     wdata_a_i,
    input  logic [DATA_WIDTH-1:0]     wdata_b_i,
    output logic                      rvalid_a_o,
    output logic                      rvalid_b_o,
    output logic [DATA_WIDTH-1:0]     rdata_a_o,
    output logic [DATA_WIDTH-1:0]     rdata_b_o,
    output logic                      err_a_o,
    output logic                      err_b_o,
    output logic                      coll_o,
    output logic [CNT_WIDTH-1:0]      coll_cnt_o
);
    localparam int                    c_BE_W      = DATA_WIDTH / 8;
    localparam int                    c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   c_DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  c_CNT_MAX   = '1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_req      [2];
    logic                  w_we       [2];
    logic                  w_gnt      [2];
    logic                  w_in_range [2];
    logic                  w_rvalid   [2];
    logic                  w_err      [2];
    logic [ADDR_WIDTH-1:0] w_addr     [2];
    logic [c_IDX_W-1:0]    w_idx      [2];
    logic [c_BE_W-1:0]     w_be       [2];
    logic [DATA_WIDTH-1:0] w_wdata    [2];
    logic [DATA_WIDTH-1:0] w_rdata    [2];

    logic                  w_coll;
    logic                  r_prio;
    logic                  r_coll;
    logic [CNT_WIDTH-1:0]  r_coll_cnt;

    assign w_req[0]   = req_a_i;
    assign w_req[1]   = req_b_i;
    assign w_we[0]    = we_a_i;
    assign w_we[1]    = we_b_i;
    assign w_addr[0]  = addr_a_i;
    assign w_addr[1]  = addr_b_i;
    assign w_be[0]    = be_a_i;
    assign w_be[1]    = be_b_i;
    assign w_wdata[0] = wdata_a_i;
    assign w_wdata[1] = wdata_b_i;

    // Two reads of the same word never conflict; any write involvement does.
    assign w_coll   = !rst_i && w_req[0] && w_req[1] &&
                      (w_addr[0] == w_addr[1]) && (w_we[0] || w_we[1]);
    assign w_gnt[0] = !rst_i && w_req[0] && !(w_coll && r_prio);
    assign w_gnt[1] = !rst_i && w_req[1] && !(w_coll && !r_prio);

    // Priority moves to the stalled port, bounding any stall to one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio     <= 1'b0;
            r_coll     <= 1'b0;
            r_coll_cnt <= '0;
        end else begin
            r_coll <= w_coll;
            if (w_coll) begin
                r_prio <= !r_prio;
                if (r_coll_cnt != c_CNT_MAX) begin
                    r_coll_cnt <= r_coll_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < 2; p++) begin
            if (w_gnt[p] && w_we[p] && w_in_range[p]) begin
                for (int b = 0; b < c_BE_W; b++) begin
                    if (w_be[p][b]) begin
                        r_mem[w_idx[p]][8*b +: 8] <= w_wdata[p][8*b +: 8];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  r_rv1;
        logic                  r_rerr1;
        logic                  r_werr1;
        logic [DATA_WIDTH-1:0] r_rd1;

        assign w_idx[p]      = w_addr[p][c_IDX_W-1:0];
        assign w_in_range[p] = ({1'b0, w_addr[p]} < c_DEPTH_EXT);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_rv1   <= 1'b0;
                r_rerr1 <= 1'b0;
                r_werr1 <= 1'b0;
                r_rd1   <= '0;
            end else begin
                r_rv1   <= w_gnt[p] && !w_we[p];
                r_rerr1 <= w_gnt[p] && !w_we[p] && !w_in_range[p];
                r_werr1 <= w_gnt[p] && w_we[p] && !w_in_range[p];
                if (w_gnt[p] && !w_we[p]) begin
                    r_rd1 <= w_in_range[p] ? r_mem[w_idx[p]] : '0;
                end
            end
        end

        // Write errors always report one cycle after grant; read errors ride with rvalid.
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_rv2;
            logic                  r_rerr2;
            logic [DATA_WIDTH-1:0] r_rd2;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_rv2   <= 1'b0;
                    r_rerr2 <= 1'b0;
                    r_rd2   <= '0;
                end else begin
                    r_rv2   <= r_rv1;
                    r_rerr2 <= r_rerr1;
                    if (r_rv1) begin
                        r_rd2 <= r_rd1;
                    end
                end
            end

            assign w_rvalid[p] = r_rv2;
            assign w_rdata[p]  = r_rd2;
            assign w_err[p]    = r_rerr2 || r_werr1;
        end else begin : g_no_out_reg
            assign w_rvalid[p] = r_rv1;
            assign w_rdata[p]  = r_rd1;
            assign w_err[p]    = r_rerr1 || r_werr1;
        end
    end

    assign gnt_a_o    = w_gnt[0];
    assign gnt_b_o    = w_gnt[1];
    assign rvalid_a_o = w_rvalid[0];
    assign rvalid_b_o = w_rvalid[1];
    assign rdata_a_o  = w_rdata[0];
    assign rdata_b_o  = w_rdata[1];
    assign err_a_o    = w_err[0];
    assign err_b_o    = w_err[1];
    assign coll_o     = r_coll;
    assign coll_cnt_o = r_coll_cnt;

endmodule
`default_nettype wire
